// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Opcode map, sequencer state encoding and opcode classifiers.
// Revision : 1.0 - initial release
// =============================================================================
package alu_ctrl_pkg;

   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'd1;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'd3;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'd4;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'd5;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'd6;
   localparam logic [OPC_W-1:0] OP_SHRA = 5'd7;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'd8;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'd9;
   localparam logic [OPC_W-1:0] OP_AND  = 5'd10;
   localparam logic [OPC_W-1:0] OP_OR   = 5'd11;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'd12;
   localparam logic [OPC_W-1:0] OP_XOR  = 5'd13;
   localparam logic [OPC_W-1:0] OP_NOR  = 5'd14;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'd15;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ILL   = 4'd1,
      S_YLOAD = 4'd2,
      S_OP    = 4'd3,
      S_WAIT  = 4'd4,
      S_ZLAT  = 4'd5,
      S_TMO   = 4'd6,
      S_WBLO  = 4'd7,
      S_WBHI  = 4'd8
   } state_t;

   function automatic logic is_legal(input logic [OPC_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_NOT);
   endfunction

   function automatic logic is_unary(input logic [OPC_W-1:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic is_multi(input logic [OPC_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_wait_timer.sv
`default_nettype none
// =============================================================================
// Module   : alu_wait_timer
// Brief    : 8-bit clear/enable counter flagging the last permitted wait cycle.
// Revision : 1.0 - initial release
// =============================================================================
module alu_wait_timer #(
   parameter int WAIT_TIMEOUT = 64
) (
   input  logic clk,
   input  logic clr,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [7:0] c_expire_count = 8'(WAIT_TIMEOUT - 1);

   logic [7:0] r_count;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_expired = (r_count == c_expire_count);

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : alu_op_sequencer
// Brief    : Steps the ALU datapath through Y load, execute and Z writeback.
// Revision : 1.0 - initial release
// =============================================================================
module alu_op_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int REG_IDX_W    = 4,
   parameter int OPCODE_W     = 5,
   parameter int WAIT_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic [REG_IDX_W-1:0] ra,
   input  logic [REG_IDX_W-1:0] rb,
   input  logic [REG_IDX_W-1:0] rc,
   output logic                 busy,
   output logic                 done,
   output logic                 illegal,
   output logic                 timeout,
   output logic                 reg_out_en,
   output logic [REG_IDX_W-1:0] reg_out_sel,
   output logic                 y_in,
   output logic [OPCODE_W-1:0]  alu_opcode,
   output logic                 alu_start,
   input  logic                 alu_done,
   output logic                 z_in,
   output logic                 zlow_out,
   output logic                 zhigh_out,
   output logic                 reg_in_en,
   output logic [REG_IDX_W-1:0] reg_in_sel,
   output logic                 lo_in,
   output logic                 hi_in
);

   state_t                r_state;
   state_t                w_next_state;
   logic [OPCODE_W-1:0]   r_opcode;
   logic [REG_IDX_W-1:0]  r_ra;
   logic [REG_IDX_W-1:0]  r_rb;
   logic [REG_IDX_W-1:0]  r_rc;
   logic                  w_tmr_clear;
   logic                  w_tmr_en;
   logic                  w_tmr_expired;
   logic                  w_accept;

   assign w_accept = (r_state == S_IDLE) && start && is_legal(opcode);

   alu_wait_timer #(
      .WAIT_TIMEOUT (WAIT_TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .clr       (clr),
      .i_clear   (w_tmr_clear),
      .i_enable  (w_tmr_en),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_ra     <= '0;
         r_rb     <= '0;
         r_rc     <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_opcode <= opcode;
            r_ra     <= ra;
            r_rb     <= rb;
            r_rc     <= rc;
         end
      end
   end

   // Outputs decode only state and captured fields, so no input reaches an output.
   always_comb begin
      w_next_state = r_state;
      w_tmr_clear  = 1'b0;
      w_tmr_en     = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      illegal      = 1'b0;
      timeout      = 1'b0;
      reg_out_en   = 1'b0;
      reg_out_sel  = '0;
      y_in         = 1'b0;
      alu_opcode   = '0;
      alu_start    = 1'b0;
      z_in         = 1'b0;
      zlow_out     = 1'b0;
      zhigh_out    = 1'b0;
      reg_in_en    = 1'b0;
      reg_in_sel   = '0;
      lo_in        = 1'b0;
      hi_in        = 1'b0;

      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next_state = is_legal(opcode) ? S_YLOAD : S_ILL;
            end
         end
         S_ILL: begin
            illegal      = 1'b1;
            w_next_state = S_IDLE;
         end
         S_YLOAD: begin
            reg_out_en   = 1'b1;
            reg_out_sel  = r_rb;
            y_in         = 1'b1;
            w_next_state = S_OP;
         end
         S_OP: begin
            alu_opcode = r_opcode;
            if (!is_unary(r_opcode)) begin
               reg_out_en  = 1'b1;
               reg_out_sel = r_rc;
            end
            if (is_multi(r_opcode)) begin
               alu_start    = 1'b1;
               w_tmr_clear  = 1'b1;
               w_next_state = S_WAIT;
            end else begin
               z_in         = 1'b1;
               w_next_state = S_WBLO;
            end
         end
         S_WAIT: begin
            reg_out_en  = 1'b1;
            reg_out_sel = r_rc;
            alu_opcode  = r_opcode;
            w_tmr_en    = 1'b1;
            // A result arriving on the last permitted cycle still completes.
            if (alu_done) begin
               w_next_state = S_ZLAT;
            end else if (w_tmr_expired) begin
               w_next_state = S_TMO;
            end
         end
         S_ZLAT: begin
            z_in         = 1'b1;
            alu_opcode   = r_opcode;
            w_next_state = S_WBLO;
         end
         S_TMO: begin
            timeout      = 1'b1;
            w_next_state = S_IDLE;
         end
         S_WBLO: begin
            zlow_out = 1'b1;
            if (is_multi(r_opcode)) begin
               lo_in        = 1'b1;
               w_next_state = S_WBHI;
            end else begin
               reg_in_en    = 1'b1;
               reg_in_sel   = r_ra;
               done         = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         S_WBHI: begin
            zhigh_out    = 1'b1;
            hi_in        = 1'b1;
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            busy         = 1'b0;
            w_next_state = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
